// File: rtl/cycle_cooling_system.sv
// cycle_cooling_system: fuses four sensor codes into a ramp-limited fan speed with overheat override and idle shut-off
module cycle_cooling_system #(
    parameter int RAMP_CYCLES = 4,
    parameter int IDLE_CYCLES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] calorie,
    input  logic [2:0] temperature,
    input  logic [2:0] pressure,
    input  logic [2:0] air_pressure,
    output logic [2:0] fan_mode
);
    localparam int RW = $clog2(RAMP_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    typedef enum logic [1:0] {OFF, RUN, OVERHEAT} state_t;
    state_t state;
    logic [2:0] c_r, t_r, p_r, a_r, target;
    logic [4:0] demand, net, tq;
    logic [RW-1:0] ramp_cnt;
    logic [IW-1:0] idle_cnt;
    always_comb begin
        demand = 5'(c_r) + 5'(t_r) + 5'(p_r);
        net = demand > 5'(a_r) ? demand - 5'(a_r) : 5'd0;
        tq = (net + 5'd2) / 5'd3;
        target = tq > 5'd7 ? 3'd7 : tq[2:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_r <= '0;
            t_r <= '0;
            p_r <= '0;
            a_r <= '0;
            state <= OFF;
            fan_mode <= '0;
            ramp_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            c_r <= calorie;
            t_r <= temperature;
            p_r <= pressure;
            a_r <= air_pressure;
            if (t_r == 3'd7) begin
                state <= OVERHEAT;
                fan_mode <= 3'd7;
                ramp_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    OVERHEAT: begin
                        if (t_r <= 3'd5) state <= RUN;
                    end
                    RUN: begin
                        idle_cnt <= p_r != 3'd0 ? '0 : idle_cnt + 1'b1;
                        // idle timeout drops straight to off, bypassing the ramp
                        if (p_r == 3'd0 && idle_cnt == IDLE_LAST) begin
                            state <= OFF;
                            fan_mode <= '0;
                            ramp_cnt <= '0;
                            idle_cnt <= '0;
                        end else if (fan_mode == target) begin
                            ramp_cnt <= '0;
                        end else if (ramp_cnt == RAMP_LAST) begin
                            ramp_cnt <= '0;
                            fan_mode <= fan_mode < target ? fan_mode + 3'd1 : fan_mode - 3'd1;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end
                    default: begin
                        fan_mode <= '0;
                        ramp_cnt <= '0;
                        idle_cnt <= '0;
                        if (p_r != 3'd0 && target != 3'd0) state <= RUN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cycle_cooling_system.sv
// tb_cycle_cooling_system: directed checks of ramp, reset, idle timeout, overheat and saturation
module tb_cycle_cooling_system;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] calorie, temperature, pressure, air_pressure;
    logic [2:0] fan_mode;
    int checks = 0;
    int errors = 0;
    cycle_cooling_system #(.RAMP_CYCLES(4), .IDLE_CYCLES(60)) dut (
        .clk(clk),
        .rst(rst),
        .calorie(calorie),
        .temperature(temperature),
        .pressure(pressure),
        .air_pressure(air_pressure),
        .fan_mode(fan_mode)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set(input int c, input int t, input int p, input int a);
        calorie = 3'(c);
        temperature = 3'(t);
        pressure = 3'(p);
        air_pressure = 3'(a);
    endtask
    task automatic chk(input string tag, input int e, input int exp);
        checks++;
        assert (fan_mode === 3'(exp))
        else begin
            errors++;
            $error("FAIL %s edge=%0d fan_mode=%0d expected=%0d", tag, e, fan_mode, exp);
        end
    endtask
    initial begin
        rst = 1'b0;
        set(2, 2, 1, 1);
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("reset_hold", e, 0);
        end
        set(2, 2, 2, 2);
        rst = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("ramp_up", e, e < 6 ? 0 : (e < 10 ? 1 : 2));
        end
        repeat (188) step();
        chk("steady_200", 200, 2);
        rst = 1'b0;
        step();
        chk("mid_reset", 0, 0);
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 5 || e == 6 || e == 10) chk("restart_ramp", e, e < 6 ? 0 : (e < 10 ? 1 : 2));
        end
        rst = 1'b0;
        step();
        set(2, 2, 0, 2);
        rst = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            step();
            chk("no_pedal_off", e, 0);
        end
        rst = 1'b0;
        step();
        set(3, 3, 2, 2);
        rst = 1'b1;
        repeat (12) step();
        chk("idle_pre", 12, 2);
        set(3, 3, 0, 2);
        for (int e = 1; e <= 61; e++) begin
            step();
            chk("idle_timeout", e, e < 61 ? 2 : 0);
        end
        set(3, 3, 2, 2);
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 5 || e == 6 || e == 10) chk("idle_restart", e, e < 6 ? 0 : (e < 10 ? 1 : 2));
        end
        set(3, 7, 2, 2);
        for (int e = 1; e <= 2; e++) begin
            step();
            chk("overheat_entry", e, e < 2 ? 2 : 7);
        end
        set(3, 6, 2, 2);
        for (int e = 1; e <= 5; e++) begin
            step();
            chk("overheat_hyst", e, 7);
        end
        set(3, 3, 2, 2);
        for (int e = 1; e <= 30; e++) begin
            int x;
            step();
            x = e < 6 ? 7 : 7 - (e - 2) / 4;
            chk("overheat_rampdown", e, x < 2 ? 2 : x);
        end
        rst = 1'b0;
        step();
        set(7, 6, 7, 0);
        rst = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            int x;
            step();
            x = e < 2 ? 0 : (e - 2) / 4;
            chk("ramp_to_max", e, x > 7 ? 7 : x);
        end
        set(7, 7, 7, 0);
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("max_inputs", e, 7);
        end
        set(7, 5, 7, 0);
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("target_seven", e, 7);
        end
        set(0, 0, 1, 7);
        for (int e = 1; e <= 32; e++) begin
            int x;
            step();
            x = 7 - (e - 1) / 4;
            chk("net_saturate", e, x < 0 ? 0 : x);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
